// File: rtl/grv_stats_monitor.sv
// Block statistics monitor for a Gaussian sample stream: mean, mean square,
// peak magnitude and tail-event count over blocks of 2^LOG2N samples.
module grv_stats_monitor #(
  parameter int unsigned LOG2N    = 10,
  parameter logic [15:0] TAIL_THR = 16'd6144
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      grv,
  input  logic             outputvalid,
  input  logic             result_ack,
  output logic [15:0]      mean,
  output logic [31:0]      meansq,
  output logic [15:0]      peak,
  output logic [LOG2N:0]   tail_count,
  output logic             result_valid,
  output logic             missed
);

  localparam int unsigned SumW = 16 + LOG2N;
  localparam int unsigned SqW  = 32 + LOG2N;
  localparam int unsigned CntW = LOG2N + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((64'd1 << LOG2N) - 64'd1);

  typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

  state_e          state_q, state_d;
  logic [SumW-1:0] sum_q, sum_d;
  logic [SqW-1:0]  sumsq_q, sumsq_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     pk_acc_q, pk_acc_d;
  logic [CntW-1:0] tail_acc_q, tail_acc_d;
  logic [15:0]     mean_q, mean_d;
  logic [31:0]     meansq_q, meansq_d;
  logic [15:0]     peak_q, peak_d;
  logic [CntW-1:0] tail_q, tail_d;
  logic            valid_q, valid_d;
  logic            missed_q, missed_d;

  // Per-sample arithmetic; abs is 17 bits so -32768 maps exactly to 32768.
  logic [16:0]     abs17;
  logic [15:0]     abs_sat;
  logic [31:0]     sq;
  logic            tail_hit;
  logic [SumW-1:0] sum_acc;
  logic [SqW-1:0]  sumsq_acc;
  logic [15:0]     pk_acc;
  logic [CntW-1:0] tail_acc;

  // Candidate accumulator values if the current sample is accepted.
  always_comb begin
    abs17     = grv[15] ? (17'd0 - {1'b1, grv}) : {1'b0, grv};
    abs_sat   = (abs17 > 17'd32767) ? 16'h7FFF : abs17[15:0];
    // abs17[16] is never set (max magnitude is 32768), so 16 bits suffice here.
    sq        = {16'd0, abs17[15:0]} * {16'd0, abs17[15:0]};
    tail_hit  = (abs17 >= {1'b0, TAIL_THR});
    sum_acc   = sum_q + {{LOG2N{grv[15]}}, grv};
    sumsq_acc = sumsq_q + SqW'(sq);
    pk_acc    = (abs_sat > pk_acc_q) ? abs_sat : pk_acc_q;
    tail_acc  = tail_acc_q + CntW'(tail_hit);
  end

  // Next-state logic for the FSM, accumulators and result registers.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    sumsq_d    = sumsq_q;
    cnt_d      = cnt_q;
    pk_acc_d   = pk_acc_q;
    tail_acc_d = tail_acc_q;
    mean_d     = mean_q;
    meansq_d   = meansq_q;
    peak_d     = peak_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    missed_d   = missed_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          sum_d      = '0;
          sumsq_d    = '0;
          cnt_d      = '0;
          pk_acc_d   = '0;
          tail_acc_d = '0;
          missed_d   = 1'b0;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        if (outputvalid) begin
          sum_d      = sum_acc;
          sumsq_d    = sumsq_acc;
          cnt_d      = cnt_q + CntW'(1);
          pk_acc_d   = pk_acc;
          tail_acc_d = tail_acc;
          if (cnt_q == LastCnt) begin
            // Low bits of the shifted sums; the slice is the arithmetic shift.
            mean_d   = sum_acc[LOG2N +: 16];
            meansq_d = sumsq_acc[LOG2N +: 32];
            peak_d   = pk_acc;
            tail_d   = tail_acc;
            valid_d  = 1'b1;
            state_d  = StReport;
          end
        end
      end
      StReport: begin
        if (outputvalid) missed_d = 1'b1;
        if (result_ack) begin
          valid_d = 1'b0;
          if (enable) begin
            // Back-to-back restart keeps the missed flag for the consumer.
            sum_d      = '0;
            sumsq_d    = '0;
            cnt_d      = '0;
            pk_acc_d   = '0;
            tail_acc_d = '0;
            state_d    = StAccum;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      sumsq_q    <= '0;
      cnt_q      <= '0;
      pk_acc_q   <= '0;
      tail_acc_q <= '0;
      mean_q     <= '0;
      meansq_q   <= '0;
      peak_q     <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      sumsq_q    <= sumsq_d;
      cnt_q      <= cnt_d;
      pk_acc_q   <= pk_acc_d;
      tail_acc_q <= tail_acc_d;
      mean_q     <= mean_d;
      meansq_q   <= meansq_d;
      peak_q     <= peak_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      missed_q   <= missed_d;
    end
  end

  assign mean         = mean_q;
  assign meansq       = meansq_q;
  assign peak         = peak_q;
  assign tail_count   = tail_q;
  assign result_valid = valid_q;
  assign missed       = missed_q;

endmodule

// File: tb/tb_grv_stats_monitor.sv
// Directed bench for grv_stats_monitor with 4-sample blocks.
module tb_grv_stats_monitor;

  localparam int unsigned LOG2N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] grv = 16'h0;
  logic        outputvalid = 1'b0;
  logic        result_ack = 1'b0;
  logic [15:0] mean;
  logic [31:0] meansq;
  logic [15:0] peak;
  logic [LOG2N:0] tail_count;
  logic        result_valid;
  logic        missed;

  // Packed view {mean, meansq, peak, tail_count, result_valid, missed}.
  logic [68:0] obs;
  assign obs = {mean, meansq, peak, tail_count, result_valid, missed};

  int checks = 0;
  int failures = 0;

  grv_stats_monitor #(.LOG2N(LOG2N), .TAIL_THR(16'd6144)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .grv          (grv),
    .outputvalid  (outputvalid),
    .result_ack   (result_ack),
    .mean         (mean),
    .meansq       (meansq),
    .peak         (peak),
    .tail_count   (tail_count),
    .result_valid (result_valid),
    .missed       (missed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    grv = s;
    outputvalid = 1'b1;
    step();
    outputvalid = 1'b0;
    grv = 16'h0;
  endtask

  task automatic arm();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (obs !== 69'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 69'd0);
    end
    reset = 1'b1;
    step();
    // No enable yet: samples must be ignored.
    repeat (4) send(16'h1234);
    step();
    checks++;
    if (obs !== 69'd0) begin
      failures++;
      $display("FAIL idle_no_accum got=%h exp=%h", obs, 69'd0);
    end
  endtask

  task automatic test_basic();
    // Sample coincident with enable in IDLE must not count.
    grv = 16'h7000;
    outputvalid = 1'b1;
    arm();
    outputvalid = 1'b0;
    repeat (3) send(16'h0800);
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b exp=%b", result_valid, 1'b0);
    end
    send(16'h0800);
    checks++;
    if (obs !== {16'h0800, 32'h00400000, 16'h0800, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got=%h exp=%h", obs,
               {16'h0800, 32'h00400000, 16'h0800, 3'd0, 1'b1, 1'b0});
    end
    ack();
    checks++;
    if (obs !== {16'h0800, 32'h00400000, 16'h0800, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_ack got=%h exp=%h", obs,
               {16'h0800, 32'h00400000, 16'h0800, 3'd0, 1'b0, 1'b0});
    end
    // Samples in IDLE neither count nor set missed.
    send(16'h7FFF);
    send(16'h7FFF);
    checks++;
    if (obs !== {16'h0800, 32'h00400000, 16'h0800, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_samples got=%h exp=%h", obs,
               {16'h0800, 32'h00400000, 16'h0800, 3'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_gaps();
    arm();
    send(16'h1800);
    step();
    send(16'hE800);
    step();
    step();
    send(16'h0064);
    step();
    send(16'hFF9C);
    checks++;
    if (obs !== {16'h0000, 32'h01201388, 16'h1800, 3'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL gaps_result got=%h exp=%h", obs,
               {16'h0000, 32'h01201388, 16'h1800, 3'd2, 1'b1, 1'b0});
    end
    ack();
  endtask

  task automatic test_negative();
    arm();
    send(16'hFFFF);
    repeat (3) send(16'h0000);
    checks++;
    if (obs !== {16'hFFFF, 32'h00000000, 16'h0001, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL neg1_result got=%h exp=%h", obs,
               {16'hFFFF, 32'h00000000, 16'h0001, 3'd0, 1'b1, 1'b0});
    end
    ack();
    arm();
    send(16'h8000);
    send(16'h0000);
    // Mid-block: previous results held, valid low.
    checks++;
    if (obs !== {16'hFFFF, 32'h00000000, 16'h0001, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL neg_hold got=%h exp=%h", obs,
               {16'hFFFF, 32'h00000000, 16'h0001, 3'd0, 1'b0, 1'b0});
    end
    send(16'h0000);
    send(16'h0000);
    checks++;
    if (obs !== {16'hE000, 32'h10000000, 16'h7FFF, 3'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL min_result got=%h exp=%h", obs,
               {16'hE000, 32'h10000000, 16'h7FFF, 3'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_missed();
    grv = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      outputvalid = (i % 2 == 0);
      step();
    end
    outputvalid = 1'b0;
    checks++;
    if (obs !== {16'hE000, 32'h10000000, 16'h7FFF, 3'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL missed_hold got=%h exp=%h", obs,
               {16'hE000, 32'h10000000, 16'h7FFF, 3'd1, 1'b1, 1'b1});
    end
    // Ack with enable: restart; the sample in this cycle is dropped.
    result_ack = 1'b1;
    enable = 1'b1;
    outputvalid = 1'b1;
    grv = 16'h2222;
    step();
    result_ack = 1'b0;
    enable = 1'b0;
    outputvalid = 1'b0;
    grv = 16'h0;
    checks++;
    if (obs !== {16'hE000, 32'h10000000, 16'h7FFF, 3'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL restart_ack got=%h exp=%h", obs,
               {16'hE000, 32'h10000000, 16'h7FFF, 3'd1, 1'b0, 1'b1});
    end
    repeat (4) send(16'h0100);
    checks++;
    if (obs !== {16'h0100, 32'h00010000, 16'h0100, 3'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL restart_result got=%h exp=%h", obs,
               {16'h0100, 32'h00010000, 16'h0100, 3'd0, 1'b1, 1'b1});
    end
    ack();
  endtask

  task automatic test_accum_ignore();
    arm();
    send(16'h0200);
    send(16'h0200);
    enable = 1'b1;
    result_ack = 1'b1;
    step();
    enable = 1'b0;
    result_ack = 1'b0;
    send(16'h0200);
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL accum_early_valid got=%b exp=%b", result_valid, 1'b0);
    end
    send(16'h0200);
    checks++;
    if (obs !== {16'h0200, 32'h00040000, 16'h0200, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL accum_result got=%h exp=%h", obs,
               {16'h0200, 32'h00040000, 16'h0200, 3'd0, 1'b1, 1'b0});
    end
    ack();
  endtask

  task automatic test_reset_mid();
    arm();
    send(16'h1000);
    send(16'h1000);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 69'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, 69'd0);
    end
    step();
    reset = 1'b1;
    send(16'h1000);
    send(16'h1000);
    checks++;
    if (obs !== 69'd0) begin
      failures++;
      $display("FAIL post_reset_idle got=%h exp=%h", obs, 69'd0);
    end
    arm();
    repeat (4) send(16'h0400);
    checks++;
    if (obs !== {16'h0400, 32'h00100000, 16'h0400, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_result got=%h exp=%h", obs,
               {16'h0400, 32'h00100000, 16'h0400, 3'd0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_negative();
    test_missed();
    test_accum_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grv_stats_monitor.md
GRV_STATS_MONITOR -- requirements
Module: grv_stats_monitor

Interface
REQ-001 Parameter LOG2N, default 10, log2 of samples per measurement block (allowed 1..16).
REQ-002 Parameter TAIL_THR, default 16'd6144, tail threshold on |grv| in raw LSBs (3.0 in Q4.11).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  arm request; starts a measurement block.
REQ-006 grv  input  16  Gaussian sample from the generator, two's complement, Q4.11 (sign, 4 integer, 11 fraction bits).
REQ-007 outputvalid  input  1  sample strobe; grv is valid in each cycle this is high.
REQ-008 result_ack  input  1  consumer acknowledge of the current result.
REQ-009 mean  output  16  signed block mean, raw LSBs.
REQ-010 meansq  output  32  unsigned block mean of grv squared, raw LSB^2.
REQ-011 peak  output  16  unsigned maximum |grv| in the block, saturated to 16'h7FFF.
REQ-012 tail_count  output  LOG2N+1  count of samples with |grv| >= TAIL_THR.
REQ-013 result_valid  output  1  result registers hold a completed block.
REQ-014 missed  output  1  sticky flag: a sample arrived while the result was waiting for acknowledge.

Function
REQ-015 FSM states IDLE, ACCUM, REPORT; reset state is IDLE.
REQ-016 IDLE: enable=1 clears the accumulators, the sample counter, peak, tail and missed; the next state is ACCUM; a sample in the same cycle is not counted.
REQ-017 IDLE: outputvalid is ignored, and missed is not set.
REQ-018 ACCUM: each cycle with outputvalid=1 accepts one sample; gaps in outputvalid are allowed and do not affect results.
REQ-019 Accept: sum += sign-extended grv (16+LOG2N bits, no overflow possible); sumsq += grv*grv (32+LOG2N bits unsigned); cnt += 1.
REQ-020 Accept: abs = 17-bit |grv|; peak = max(peak, min(abs, 32767)); tail increments when abs >= TAIL_THR.
REQ-021 On acceptance of sample number 2^LOG2N: the next state is REPORT; in the following cycle mean = sum >>> LOG2N (arithmetic shift, rounds toward minus infinity), meansq = sumsq >> LOG2N (low 32 bits), peak and tail_count are updated, and result_valid=1.
REQ-022 Latency: result_valid rises exactly one cycle after the last sample is accepted.
REQ-023 ACCUM: enable is ignored; result_valid stays 0; result outputs hold the previous block's values.
REQ-024 REPORT: result outputs are stable while result_ack=0; each outputvalid=1 sets missed=1 and the sample is dropped.
REQ-025 REPORT with result_ack=1: result_valid=0 next cycle; the next state is ACCUM if enable=1 in the same cycle (accumulators cleared, missed kept), otherwise IDLE.
REQ-026 result_ack outside REPORT has no effect.
REQ-027 Squares and absolutes of -32768 are computed exactly: square 2^30, abs 32768 (counted by tail, peak saturates).

Reset
REQ-028 reset=0 asynchronously forces IDLE and sets mean, meansq, peak, tail_count, result_valid, missed and all internal accumulators and counters to 0, including mid-block.
REQ-029 After reset is released, nothing is accumulated until a new enable is seen in IDLE.

Verification (LOG2N=2, TAIL_THR=6144)
REQ-030 enable, then grv=16'h0800 x4 -> mean 16'h0800, meansq 32'h00400000, peak 16'h0800, tail_count 0, result_valid one cycle after the 4th sample.
REQ-031 Samples +6144, -6144, +100, -100 with idle gaps -> mean 0, meansq 32'h01201388, peak 16'h1800, tail_count 2.
REQ-032 Samples -1, 0, 0, 0 -> mean 16'hFFFF, meansq 0; samples -32768, 0, 0, 0 -> mean 16'hE000, meansq 32'h10000000, peak 16'h7FFF, tail_count 1.
REQ-033 Hold result_ack=0 for 5 cycles with outputvalid pulses -> outputs unchanged, missed=1; then result_ack=1 with enable=1 -> result_valid=0 next cycle, new block counts samples from the following cycle, missed still 1.
REQ-034 reset low after 2 accepted samples -> all outputs 0, IDLE; after enable, 4 fresh samples of 16'h0400 -> mean 16'h0400 (no residue from before reset).
REQ-035 enable pulsed during ACCUM and result_ack pulsed during ACCUM -> no restart and no effect on results.
